// File: rtl/mv_row_accumulator_if.sv
// Beat stream into the row accumulator and row-result write port out of it.
//  master: the pacing controller / bench (drives beats, observes results)
//  slave : mv_row_accumulator
//  Beat side  : in_valid, m_data, v_data, zero_in, last, rows_over
//  Result side: res_we, res_addr {bank,row}, res_data, done, bank
interface mv_row_accumulator_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ROW_W  = 9
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] m_data;
  logic signed [DATA_W-1:0] v_data;
  logic                     zero_in;
  logic                     last;
  logic                     rows_over;

  logic                     res_we;
  logic [ROW_W:0]           res_addr;
  logic signed [OUT_W-1:0]  res_data;
  logic                     done;
  logic                     bank;

  modport master (
    output in_valid, m_data, v_data, zero_in, last, rows_over,
    input  res_we, res_addr, res_data, done, bank
  );

  modport slave (
    input  in_valid, m_data, v_data, zero_in, last, rows_over,
    output res_we, res_addr, res_data, done, bank
  );
endinterface

// File: rtl/mv_row_accumulator.sv
// Datapath end of the matrix-vector engine: multiplies each matrix/vector beat,
// accumulates per row under the controller's zero_in/last/rows_over tags and
// writes each finished, saturated row sum to a ping-pong vector BRAM bank.
// Ports:
//  clk    rising-edge clock
//  rstn   async active-low reset
//  bus    mv_row_accumulator_if.slave (beat stream in, row-result writes out)
module mv_row_accumulator #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned ROW_W      = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  mv_row_accumulator_if.slave  bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  // Row-sum clamp bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_LO  = ~SAT_HI;
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic zero_in;
    logic last;
    logic rows_over;
  } tag_t;

  tag_t                                 in_tag_q;
  logic signed [DATA_W-1:0]             m_q;
  logic signed [DATA_W-1:0]             v_q;
  logic signed [PROD_W-1:0]             prod_c;
  logic [MUL_STAGES-1:0][PROD_W-1:0]    prod_q;
  tag_t [MUL_STAGES-1:0]                tag_q;

  tag_t                                 tag_out;
  logic signed [PROD_W-1:0]             p_out;
  logic signed [ACC_W-1:0]              p_ext_c;
  logic signed [ACC_W-1:0]              sum_c;
  logic [OUT_W-1:0]                     sat_c;

  logic signed [ACC_W-1:0]              acc_q;
  logic [ROW_W-1:0]                     row_q;
  logic                                 bank_q;
  logic                                 res_we_q;
  logic                                 done_q;
  logic [ROW_W:0]                       res_addr_q;
  logic [OUT_W-1:0]                     res_data_q;

  // Operand capture; tags are forced low on invalid beats so bubbles carry nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_tag_q <= '0;
      m_q      <= '0;
      v_q      <= '0;
    end else begin
      in_tag_q.valid     <= bus.in_valid;
      in_tag_q.zero_in   <= bus.in_valid & bus.zero_in;
      in_tag_q.last      <= bus.in_valid & bus.last;
      in_tag_q.rows_over <= bus.in_valid & bus.rows_over;
      m_q                <= bus.m_data;
      v_q                <= bus.v_data;
    end
  end

  // Sign-extend both operands first so the product is full precision.
  assign prod_c = PROD_W'(m_q) * PROD_W'(v_q);

  // Multiplier pipeline; tags travel alongside the product.
  if (MUL_STAGES == 1) begin : g_mul_one
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prod_q <= '0;
        tag_q  <= '0;
      end else begin
        prod_q <= prod_c;
        tag_q  <= in_tag_q;
      end
    end
  end else begin : g_mul_many
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prod_q <= '0;
        tag_q  <= '0;
      end else begin
        prod_q <= {prod_q[MUL_STAGES-2:0], prod_c};
        tag_q  <= {tag_q[MUL_STAGES-2:0], in_tag_q};
      end
    end
  end

  assign tag_out = tag_q[MUL_STAGES-1];
  assign p_out   = prod_q[MUL_STAGES-1];

  // Row sum and clamp to the output width.
  always_comb begin
    p_ext_c = ACC_W'(p_out);
    sum_c   = tag_out.zero_in ? p_ext_c : acc_q + p_ext_c;
    sat_c   = sum_c[OUT_W-1:0];
    if (sum_c > SAT_HI) begin
      sat_c = OUT_MAX;
    end else if (sum_c < SAT_LO) begin
      sat_c = OUT_MIN;
    end
  end

  // Accumulator, row/bank bookkeeping and registered write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      row_q      <= '0;
      bank_q     <= 1'b0;
      res_we_q   <= 1'b0;
      done_q     <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      res_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (tag_out.valid) begin
        acc_q <= sum_c;
        if (tag_out.last) begin
          res_we_q   <= 1'b1;
          res_data_q <= sat_c;
          res_addr_q <= {bank_q, row_q};
          row_q      <= row_q + ROW_W'(1);
          // Pass end: restart rows in the other bank; this write keeps the old bank.
          if (tag_out.rows_over) begin
            done_q <= 1'b1;
            row_q  <= '0;
            bank_q <= ~bank_q;
          end
        end
      end
    end
  end

  assign bus.res_we   = res_we_q;
  assign bus.done     = done_q;
  assign bus.res_addr = res_addr_q;
  assign bus.res_data = res_data_q;
  assign bus.bank     = bank_q;

endmodule

// File: tb/tb_mv_row_accumulator.sv
// Directed bench for mv_row_accumulator: drives beats on the falling edge,
// logs every write/done cycle, and compares the log against hand-computed rows.
module tb_mv_row_accumulator;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;
  int   last_edge;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } rec_t;

  rec_t q[$];
  rec_t r;

  mv_row_accumulator_if bus ();

  mv_row_accumulator dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle with a write strobe or done pulse.
  always @(negedge clk) begin
    if (rstn && (bus.res_we || bus.done)) begin
      q.push_back('{bus.res_we, bus.res_addr, bus.res_data, bus.done, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input int m, input int v,
                       input logic z, input logic l, input logic ro);
    @(negedge clk);
    bus.in_valid  = vld;
    bus.m_data    = 16'(m);
    bus.v_data    = 16'(v);
    bus.zero_in   = z;
    bus.last      = l;
    bus.rows_over = ro;
    last_edge     = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag, output rec_t rr);
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed no write, expected a write", tag);
    end
    if (q.size() > 0) rr = q.pop_front();
    else rr = '{1'b0, 10'h3ff, 32'hdead_beef, 1'b0, -1};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.zero_in   = 1'b0;
    bus.last      = 1'b0;
    bus.rows_over = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.m_data    = '0;
    bus.v_data    = '0;
    bus.zero_in   = 1'b0;
    bus.last      = 1'b0;
    bus.rows_over = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_we",   32'(bus.res_we),   32'd0);
    check("rst_addr", 32'(bus.res_addr), 32'd0);
    check("rst_data", 32'(bus.res_data), 32'd0);
    check("rst_done", 32'(bus.done),     32'd0);
    check("rst_bank", 32'(bus.bank),     32'd0);

    // T1: 2*3 + 4*5 + (-1)*6 = 20, strobe three edges after the last beat
    drive(1'b1, 2, 3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4, 5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, -1, 6, 1'b0, 1'b1, 1'b0);
    begin
      int k;
      k = last_edge;
      idle(5);
      pop("t1_rec", r);
      check("t1_data", r.data, 32'd20);
      check("t1_addr", 32'(r.addr), 32'd0);
      check("t1_done", 32'(r.done), 32'd0);
      check("t1_lat",  32'(r.cyc), 32'(k + 3));
      check("t1_cnt",  32'(q.size()), 32'd0);
    end

    // T2: 13 one-beat rows, pass ends on row 12
    do_reset();
    for (int i = 0; i < 13; i++) drive(1'b1, i, 2, 1'b1, 1'b1, 1'(i == 12));
    idle(5);
    for (int i = 0; i < 13; i++) begin
      pop($sformatf("t2_rec%0d", i), r);
      check($sformatf("t2_addr%0d", i), 32'(r.addr), 32'(i));
      check($sformatf("t2_data%0d", i), r.data, 32'(2 * i));
      check($sformatf("t2_done%0d", i), 32'(r.done), 32'(i == 12));
    end
    check("t2_bank", 32'(bus.bank), 32'd1);
    check("t2_cnt",  32'(q.size()), 32'd0);

    // T3: second pass lands in bank 1, done flips back to bank 0
    for (int i = 0; i < 3; i++) drive(1'b1, i + 1, -3, 1'b1, 1'b1, 1'(i == 2));
    idle(5);
    for (int i = 0; i < 3; i++) begin
      pop($sformatf("t3_rec%0d", i), r);
      check($sformatf("t3_addr%0d", i), 32'(r.addr), 32'(512 + i));
      check($sformatf("t3_data%0d", i), r.data, 32'(-3 * (i + 1)));
      check($sformatf("t3_done%0d", i), 32'(r.done), 32'(i == 2));
    end
    check("t3_bank", 32'(bus.bank), 32'd0);

    // T4: saturation high, low, and exactly 2^31
    drive(1'b1, 32767, 32767, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b1, 1'b0);
    drive(1'b1, -32768, 32767, 1'b1, 1'b0, 1'b0);
    drive(1'b1, -32768, 32767, 1'b0, 1'b0, 1'b0);
    drive(1'b1, -32768, 32767, 1'b0, 1'b0, 1'b0);
    drive(1'b1, -32768, 32767, 1'b0, 1'b1, 1'b0);
    drive(1'b1, -32768, -32768, 1'b1, 1'b0, 1'b0);
    drive(1'b1, -32768, -32768, 1'b0, 1'b1, 1'b0);
    idle(5);
    pop("t4_rec_hi", r);
    check("t4_hi",      r.data, 32'h7fff_ffff);
    check("t4_hi_addr", 32'(r.addr), 32'd0);
    pop("t4_rec_lo", r);
    check("t4_lo",      r.data, 32'h8000_0000);
    check("t4_lo_addr", 32'(r.addr), 32'd1);
    pop("t4_rec_edge", r);
    check("t4_edge",    r.data, 32'h7fff_ffff);

    // T5: bubbles carrying set tags must not disturb the row (21 - 10 + 16 = 27)
    drive(1'b1, 3, 7, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 99, 99, 1'b1, 1'b1, 1'b1);
    drive(1'b1, -2, 5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, -7, 11, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 4, 4, 1'b0, 1'b1, 1'b0);
    idle(5);
    pop("t5_rec", r);
    check("t5_data", r.data, 32'd27);
    check("t5_addr", 32'(r.addr), 32'd3);
    check("t5_done", 32'(r.done), 32'd0);
    check("t5_cnt",  32'(q.size()), 32'd0);
    check("t5_bank", 32'(bus.bank), 32'd0);

    // T6: move to bank 1, then reset with a row in flight
    drive(1'b1, 1, 1, 1'b1, 1'b1, 1'b1);
    idle(5);
    pop("t6_pre", r);
    check("t6_pre_addr", 32'(r.addr), 32'd4);
    check("t6_pre_done", 32'(r.done), 32'd1);
    check("t6_pre_bank", 32'(bus.bank), 32'd1);
    drive(1'b1, 5, 5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2, 2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(6);
    check("t6_none", 32'(q.size()), 32'd0);
    check("t6_bank", 32'(bus.bank), 32'd0);
    drive(1'b1, 7, 3, 1'b1, 1'b1, 1'b0);
    idle(5);
    pop("t6_rec", r);
    check("t6_data", r.data, 32'd21);
    check("t6_addr", 32'(r.addr), 32'd0);
    check("t6_done", 32'(r.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
